alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width; SHALL be a power of two >= 8.
REQ-002 Parameter: SHAMT_W, default $clog2(XLEN), shift-amount width taken from op_b LSBs.
REQ-003 Port: clk  in  1  single clock; all state SHALL update on rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous and active-high.
REQ-005 Port: in_valid  in  1  request present.
REQ-006 Port: in_ready  out  1  unit accepts a request this cycle.
REQ-007 Port: alu_op  in  2  00 add, 01 sub, 10 funct-decoded, 11 pass op_b.
REQ-008 Port: funct3  in  3  instruction funct3.
REQ-009 Port: funct7_5  in  1  instruction bit 30 (sub/sra select).
REQ-010 Port: funct7_0  in  1  instruction bit 25 (M-extension select).
REQ-011 Port: is_imm  in  1  request is I-type.
REQ-012 Port: op_a, op_b  in  XLEN each  operands.
REQ-013 Port: out_valid  out  1  result available.
REQ-014 Port: out_ready  in  1  consumer takes result.
REQ-015 Port: result  out  XLEN  operation result.
REQ-016 Port: zero  out  1  result == 0.
REQ-017 Port: illegal  out  1  decoded op unsupported; result 0.

Function
REQ-018 Transfer SHALL occur on in_valid & in_ready; operands and decoded op SHALL be registered at accept.
REQ-019 Decode (alu_op=10): funct3 0 add, or sub when funct7_5 & !is_imm; 1 sll; 2 slt (signed); 3 sltu; 4 xor; 5 srl/sra by funct7_5 (both R and I); 6 or; 7 and.
REQ-020 alu_op=10 & funct7_0 & !is_imm SHALL select M ops: funct3 0..3 mul/mulh/mulhsu/mulhu, 4..7 div/divu/rem/remu.
REQ-021 FSM states IDLE, MUL, DIV, DONE; in_ready SHALL be 1 only in IDLE.
REQ-022 IDLE->DONE on accept of base op; result SHALL be valid exactly 1 cycle after accept.
REQ-023 IDLE->MUL on accept of mul-class op; MUL->DONE after 1 cycle (latency 2).
REQ-024 IDLE->DIV on accept of div-class op; DIV->DONE when divider signals done (latency XLEN+2 cycles from accept).
REQ-025 DONE: out_valid=1, result/zero/illegal held stable; DONE->IDLE on out_ready.
REQ-026 out_ready low SHALL stall indefinitely without altering result.
REQ-027 Shifts SHALL use op_b[SHAMT_W-1:0] only; sra sign-fills.
REQ-028 Divide by zero: div/divu quotient all ones; rem/remu = op_a; no illegal flag.
REQ-029 Signed overflow (op_a = -2^(XLEN-1), op_b = -1): div = op_a, rem = 0.
REQ-030 Add/sub/mul low SHALL wrap modulo 2^XLEN; no overflow flag.

Reset
REQ-031 rst asserted SHALL force state IDLE, out_valid 0, result 0, zero 0, illegal 0, in_ready 1 after deassert, aborting any in-flight mul/div with no output.

Configuration
REQ-032 Macro ALU_EXEC_DIV_EN defined: divider sub-module instantiated, div/rem per REQ-024/028/029.
REQ-033 Macro undefined: div-class ops SHALL go IDLE->DONE in 1 cycle with illegal=1, result 0; no divider logic present.

Structure
REQ-034 Shared package alu_exec_pkg SHALL hold the alu_op encodings, internal op enum (ADD..REMU, PASS) and FSM state enum.
REQ-035 Sub-module alu_div_iter: radix-2 restoring unsigned divider with start/done, sign correction in parent.

Verification
REQ-036 XLEN=32, alu_op=10, funct3=0, is_imm=1, funct7_5=1, a=5, b=3 -> result 8 one cycle after accept (addi not sub).
REQ-037 funct3=5, funct7_5=1, a=0x80000000, b=0x24 -> result 0xF8000000 (shamt 4, sign fill).
REQ-038 mulhu a=b=0xFFFFFFFF -> result 0xFFFFFFFE, out_valid 2 cycles after accept.
REQ-039 div a=0x80000000, b=0xFFFFFFFF -> 0x80000000; divu a=7, b=0 -> 0xFFFFFFFF after 34 cycles; without ALU_EXEC_DIV_EN -> illegal=1, result 0.
REQ-040 out_ready held 0 for 5 cycles in DONE -> result stable, in_ready 0; rst pulsed during DIV -> out_valid 0, next request executes normally.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared definitions for the ALU execution unit.
//   - alu_op encodings presented by the main decoder
//   - internal operation enum (ADD..REMU, PASS)
//   - FSM state enum
//   - decode/classification helpers
package alu_exec_pkg;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_PASS  = 2'b11;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_PASS
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic op_e decode_op(
    input logic [1:0] alu_op,
    input logic [2:0] funct3,
    input logic       funct7_5,
    input logic       funct7_0,
    input logic       is_imm
  );
    op_e op;
    op = OP_ADD;
    case (alu_op)
      ALU_OP_ADD:  op = OP_ADD;
      ALU_OP_SUB:  op = OP_SUB;
      ALU_OP_PASS: op = OP_PASS;
      default: begin
        if (funct7_0 && !is_imm) begin
          case (funct3)
            3'd0: op = OP_MUL;
            3'd1: op = OP_MULH;
            3'd2: op = OP_MULHSU;
            3'd3: op = OP_MULHU;
            3'd4: op = OP_DIV;
            3'd5: op = OP_DIVU;
            3'd6: op = OP_REM;
            default: op = OP_REMU;
          endcase
        end else begin
          case (funct3)
            // funct7_5 on an I-type addi is immediate bits, not a sub select
            3'd0: op = (funct7_5 && !is_imm) ? OP_SUB : OP_ADD;
            3'd1: op = OP_SLL;
            3'd2: op = OP_SLT;
            3'd3: op = OP_SLTU;
            3'd4: op = OP_XOR;
            3'd5: op = funct7_5 ? OP_SRA : OP_SRL;
            3'd6: op = OP_OR;
            default: op = OP_AND;
          endcase
        end
      end
    endcase
    return op;
  endfunction

  function automatic logic is_mul_op(input op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

  function automatic logic is_div_op(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_div(input op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_exec_unit_div.sv
// alu_div_iter: radix-2 restoring unsigned divider, one quotient bit per
// cycle. Only built when ALU_EXEC_DIV_EN is defined.
//   clk, rst          clock, asynchronous active-high reset
//   start             load operands and begin (pulse)
//   dividend, divisor unsigned operands captured on start
//   done              level, set after XLEN iterations, cleared by start
//   quotient, remainder  valid while done is high
// Divide by zero yields quotient all ones and remainder = dividend.
`ifdef ALU_EXEC_DIV_EN
module alu_div_iter
  import alu_exec_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  dsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  logic [XLEN:0]    rem_sh;
  logic [XLEN:0]    diff;
  logic             fits;

  // rem_q < dsr_q holds between steps, so one extra bit covers the borrow
  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dsr_q};
    fits   = ~diff[XLEN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dsr_q  <= divisor;
      cnt_q  <= '0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      rem_q <= fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], fits};
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CNT_W'(XLEN - 1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule
`endif

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-issue integer execution unit (RV32I/M style).
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       request handshake (ready only in IDLE)
//   alu_op, funct3, funct7_5, funct7_0, is_imm   operation select
//   op_a, op_b                operands
//   out_valid / out_ready     result handshake (valid in DONE)
//   result, zero, illegal     result, result==0, unsupported op
// Latency: base ops 1 cycle, mul 2, div/rem XLEN+2.
// Macro ALU_EXEC_DIV_EN: builds the iterative divider; when undefined,
// div/rem complete in 1 cycle with illegal=1 and result 0.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic            is_imm,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  state_e            state_q, state_d;
  op_e               op_in, op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic              illegal_q, illegal_in;
  logic              accept;
  logic [2*XLEN-1:0] prod_q, prod_full;
  logic [2*XLEN-1:0] ext_a, ext_b;
  logic              mul_a_signed, mul_b_signed;
  logic              div_done;
  logic [XLEN-1:0]   res_comb;
  logic [SHAMT_W-1:0] shamt;
  logic              lt_s, lt_u;

  assign op_in  = decode_op(alu_op, funct3, funct7_5, funct7_0, is_imm);
  assign accept = in_valid && (state_q == ST_IDLE);

`ifdef ALU_EXEC_DIV_EN
  assign illegal_in = 1'b0;
`else
  assign illegal_in = is_div_op(op_in);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul_op(op_in)) begin
            state_d = ST_MUL;
`ifdef ALU_EXEC_DIV_EN
          end else if (is_div_op(op_in)) begin
            state_d = ST_DIV;
`endif
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_MUL: state_d = ST_DONE;
      ST_DIV: if (div_done) state_d = ST_DONE;
      default: if (out_ready) state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      illegal_q <= 1'b0;
      prod_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= op_in;
        a_q       <= op_a;
        b_q       <= op_b;
        illegal_q <= illegal_in;
      end
      if (state_q == ST_MUL) begin
        prod_q <= prod_full;
      end
    end
  end

  // One 2*XLEN multiply serves all four variants: operands are sign- or
  // zero-extended first, and the low 2*XLEN bits of the product are exact.
  always_comb begin
    mul_a_signed = (op_q == OP_MULH) || (op_q == OP_MULHSU);
    mul_b_signed = (op_q == OP_MULH);
    ext_a        = {{XLEN{mul_a_signed & a_q[XLEN-1]}}, a_q};
    ext_b        = {{XLEN{mul_b_signed & b_q[XLEN-1]}}, b_q};
    prod_full    = ext_a * ext_b;
  end

`ifdef ALU_EXEC_DIV_EN
  logic            div_start;
  logic            div_signed_in;
  logic [XLEN-1:0] div_dividend, div_divisor;
  logic [XLEN-1:0] div_quo, div_rem;
  logic            q_neg, r_neg;
  logic [XLEN-1:0] quo_fixed, rem_fixed;

  // Divider works on magnitudes; signs are restored from the held operands.
  assign div_start     = accept && is_div_op(op_in);
  assign div_signed_in = is_signed_div(op_in);
  assign div_dividend  = (div_signed_in && op_a[XLEN-1]) ? (~op_a + 1'b1) : op_a;
  assign div_divisor   = (div_signed_in && op_b[XLEN-1]) ? (~op_b + 1'b1) : op_b;

  alu_div_iter #(
    .XLEN(XLEN)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Most-negative / -1 needs no special case: |a| = 2^(XLEN-1) divided by 1
  // with equal signs already gives op_a, remainder 0.
  always_comb begin
    q_neg     = is_signed_div(op_q) && (a_q[XLEN-1] ^ b_q[XLEN-1]);
    r_neg     = is_signed_div(op_q) && a_q[XLEN-1];
    quo_fixed = q_neg ? (~div_quo + 1'b1) : div_quo;
    rem_fixed = r_neg ? (~div_rem + 1'b1) : div_rem;
    if (b_q == '0) begin
      quo_fixed = '1;
      rem_fixed = a_q;
    end
  end
`else
  assign div_done = 1'b0;
`endif

  always_comb begin
    shamt    = b_q[SHAMT_W-1:0];
    lt_s     = $signed(a_q) < $signed(b_q);
    lt_u     = a_q < b_q;
    res_comb = '0;
    case (op_q)
      OP_ADD:    res_comb = a_q + b_q;
      OP_SUB:    res_comb = a_q - b_q;
      OP_SLL:    res_comb = a_q << shamt;
      OP_SLT:    res_comb = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU:   res_comb = {{(XLEN-1){1'b0}}, lt_u};
      OP_XOR:    res_comb = a_q ^ b_q;
      OP_SRL:    res_comb = a_q >> shamt;
      OP_SRA:    res_comb = $unsigned($signed(a_q) >>> shamt);
      OP_OR:     res_comb = a_q | b_q;
      OP_AND:    res_comb = a_q & b_q;
      OP_PASS:   res_comb = b_q;
      OP_MUL:    res_comb = prod_q[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  res_comb = prod_q[2*XLEN-1:XLEN];
`ifdef ALU_EXEC_DIV_EN
      OP_DIV,
      OP_DIVU:   res_comb = quo_fixed;
      OP_REM,
      OP_REMU:   res_comb = rem_fixed;
`endif
      default:   res_comb = '0;
    endcase
  end

  // Outputs depend only on held registers in DONE, so they stay stable
  // for as long as the consumer stalls.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = (out_valid && !illegal_q) ? res_comb : '0;
  assign zero      = out_valid && (result == '0);
  assign illegal   = out_valid && illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  alu_op = 2'b00;
  logic [2:0]  funct3 = 3'd0;
  logic        funct7_5 = 1'b0;
  logic        funct7_0 = 1'b0;
  logic        is_imm = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int tests_run = 0;
  int fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
    .is_imm(is_imm), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
  );

  // Independent reference model, XLEN = 32.
  function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3,
                                 input logic f75, input logic f70, input logic imm,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int ia, ib;
    longint p;
    logic [63:0] pu;
    ia = a; ib = b;
    e.res = 32'h0; e.ill = 1'b0; e.lat = 1;
    if (op == 2'b00) e.res = a + b;
    else if (op == 2'b01) e.res = a - b;
    else if (op == 2'b11) e.res = b;
    else if (f70 && !imm) begin
      if (f3 < 3'd4) begin
        e.lat = 2;
        case (f3)
          3'd0: e.res = a * b;
          3'd1: begin p = longint'(ia) * longint'(ib); e.res = p[63:32]; end
          3'd2: begin p = longint'(ia) * longint'({32'h0, b}); e.res = p[63:32]; end
          default: begin pu = {32'h0, a} * {32'h0, b}; e.res = pu[63:32]; end
        endcase
      end else begin
`ifdef ALU_EXEC_DIV_EN
        e.lat = 34;
        case (f3)
          3'd4: e.res = (b == 0) ? 32'hFFFF_FFFF :
                        (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(ia / ib);
          3'd5: e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
          3'd6: e.res = (b == 0) ? a :
                        (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(ia % ib);
          default: e.res = (b == 0) ? a : a % b;
        endcase
`else
        e.ill = 1'b1;
        e.res = 32'h0;
`endif
      end
    end else begin
      case (f3)
        3'd0: e.res = (f75 && !imm) ? a - b : a + b;
        3'd1: e.res = a << b[4:0];
        3'd2: e.res = (ia < ib) ? 32'd1 : 32'd0;
        3'd3: e.res = (a < b) ? 32'd1 : 32'd0;
        3'd4: e.res = a ^ b;
        3'd5: e.res = f75 ? 32'(ia >>> b[4:0]) : a >> b[4:0];
        3'd6: e.res = a | b;
        default: e.res = a & b;
      endcase
    end
    return e;
  endfunction

  task automatic drive_op(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                          input logic f70, input logic imm,
                          input logic [31:0] a, input logic [31:0] b);
    sb.push_back(model(op, f3, f75, f70, imm, a, b));
    @(negedge clk);
    alu_op = op; funct3 = f3; funct7_5 = f75; funct7_0 = f70; is_imm = imm;
    op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Waits for out_valid, compares against the scoreboard head, optionally
  // stalls 'hold' cycles, then retires the result.
  task automatic wait_result(input string name, input int hold);
    int cycles;
    exp_t e;
    cycles = 1;
    while (!out_valid && cycles < 100) begin
      @(posedge clk); #1; cycles++;
    end
    e = sb.pop_front();
    tests_run++;
    if (!out_valid) begin
      fails++;
      $display("FAIL %s timeout: out_valid never rose (expected after %0d cycles)", name, e.lat);
      return;
    end
    if (result !== e.res) begin
      fails++;
      $display("FAIL %s result: got %h expected %h", name, result, e.res);
    end
    tests_run++;
    if (illegal !== e.ill || zero !== (e.res == 32'h0)) begin
      fails++;
      $display("FAIL %s flags: illegal=%b zero=%b expected illegal=%b zero=%b",
               name, illegal, zero, e.ill, (e.res == 32'h0));
    end
    tests_run++;
    if (cycles != e.lat) begin
      fails++;
      $display("FAIL %s latency: got %0d expected %0d", name, cycles, e.lat);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== e.res) begin
        fails++;
        $display("FAIL %s stall%0d: out_valid=%b in_ready=%b result=%h expected 1 0 %h",
                 name, i, out_valid, in_ready, result, e.res);
      end
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s retire: out_valid=%b in_ready=%b expected 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 ||
        zero !== 1'b0 || illegal !== 1'b0) begin
      fails++;
      $display("FAIL reset: in_ready=%b out_valid=%b result=%h zero=%b illegal=%b expected 1 0 0 0 0",
               in_ready, out_valid, result, zero, illegal);
    end
  endtask

  task automatic test_vectors;
    drive_op(2'b10, 3'd0, 1'b1, 1'b0, 1'b1, 32'd5, 32'd3);               wait_result("addi_f75", 0);
    drive_op(2'b10, 3'd0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd3);               wait_result("sub_r", 0);
    drive_op(2'b10, 3'd5, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h24);      wait_result("sra_shamt", 0);
    drive_op(2'b10, 3'd5, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h24);      wait_result("srli", 0);
    drive_op(2'b10, 3'd3, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_result("mulhu", 0);
    drive_op(2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);       wait_result("add_wrap", 0);
    drive_op(2'b11, 3'd0, 1'b0, 1'b0, 1'b0, 32'd9, 32'h0);               wait_result("pass_zero", 0);
  endtask

  task automatic test_base_ops;
    logic [1:0] op;
    logic [2:0] f3;
    logic f75, imm;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3)); f3 = 3'($urandom_range(0, 7));
      f75 = 1'($urandom_range(0, 1)); imm = 1'($urandom_range(0, 1));
      drive_op(op, f3, f75, 1'b0, imm, $urandom, (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom);
      wait_result("base_rand", 0);
    end
  endtask

  task automatic test_mul;
    drive_op(2'b10, 3'd0, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF); wait_result("mul_wrap", 0);
    drive_op(2'b10, 3'd1, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000); wait_result("mulh_neg", 0);
    drive_op(2'b10, 3'd2, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_result("mulhsu", 0);
    for (int i = 0; i < 8; i++) begin
      drive_op(2'b10, 3'(i % 4), 1'b0, 1'b1, 1'b0, $urandom, $urandom);
      wait_result("mul_rand", 0);
    end
  endtask

  task automatic test_div;
    drive_op(2'b10, 3'd4, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF); wait_result("div_ovf", 0);
    drive_op(2'b10, 3'd6, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF); wait_result("rem_ovf", 0);
    drive_op(2'b10, 3'd5, 1'b0, 1'b1, 1'b0, 32'd7, 32'd0);                wait_result("divu_by0", 0);
    drive_op(2'b10, 3'd4, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd0);        wait_result("div_by0", 0);
    drive_op(2'b10, 3'd7, 1'b0, 1'b1, 1'b0, 32'd7, 32'd0);                wait_result("remu_by0", 0);
    drive_op(2'b10, 3'd4, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);        wait_result("div_neg", 0);
    drive_op(2'b10, 3'd6, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);        wait_result("rem_neg", 0);
    for (int i = 0; i < 6; i++) begin
      drive_op(2'b10, 3'(4 + i % 4), 1'b0, 1'b1, 1'b0, $urandom, 32'($urandom_range(1, 1000)));
      wait_result("div_rand", 0);
    end
  endtask

  task automatic test_stall;
    drive_op(2'b10, 3'd7, 1'b0, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00); wait_result("stall_and", 5);
    drive_op(2'b10, 3'd1, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0); wait_result("stall_mulh", 5);
  endtask

  task automatic test_reset_abort;
    exp_t dropped;
    drive_op(2'b10, 3'd5, 1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    dropped = sb.pop_front();
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || result !== 32'h0 || in_ready !== 1'b1 || illegal !== 1'b0) begin
      fails++;
      $display("FAIL abort_reset: out_valid=%b result=%h in_ready=%b illegal=%b expected 0 0 1 0 (dropped %h)",
               out_valid, result, in_ready, illegal, dropped.res);
    end
    repeat (40) begin @(posedge clk); #1; end
    tests_run++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL abort_stale: out_valid=%b expected 0", out_valid);
    end
    drive_op(2'b10, 3'd0, 1'b0, 1'b1, 1'b0, 32'd6, 32'd7); wait_result("after_abort_mul", 0);
    drive_op(2'b10, 3'd5, 1'b0, 1'b1, 1'b0, 32'd100, 32'd7); wait_result("after_abort_divu", 0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      drive_op(2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 32'(i * 3), 32'(i));
      wait_result("b2b_add", 0);
      drive_op(2'b01, 3'd0, 1'b0, 1'b0, 1'b0, 32'(i), 32'(i));
      wait_result("b2b_sub_zero", 0);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_base_ops();
    test_mul();
    test_div();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
